// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller fed by the vehicle lamp FSM: latches requests, grants WALK on a fresh red,
// then a flashing clearance. Optional one-hot lamp check enabled by macro PED_LAMP_CHECK_EN.
module ped_crossing_ctrl #(
  parameter int unsigned WALK_TIME  = 30,
  parameter int unsigned FLASH_TIME = 16,
  parameter int unsigned FLASH_HALF = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             ped_btn,
  output logic             walk,
  output logic             dont_walk,
  output logic             req_pending,
  output logic [CNT_W-1:0] walk_remaining,
  output logic             lamp_fault
);

  localparam int unsigned FH_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam logic [CNT_W-1:0] TOTAL       = CNT_W'(WALK_TIME + FLASH_TIME);
  localparam logic [CNT_W-1:0] FLASH_START = CNT_W'(FLASH_TIME + 1);
  localparam logic [FH_W-1:0]  FH_LAST     = FH_W'(FLASH_HALF - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    FLASH = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             red_d;
  logic             red_edge;
  logic             fault_nxt;
  logic [FH_W-1:0]  flash_cnt;
  logic [FH_W-1:0]  flash_cnt_nxt;
  logic             walk_nxt;
  logic             dont_walk_nxt;
  logic             req_nxt;
  logic [CNT_W-1:0] rem_nxt;

  assign red_edge = red & ~red_d;

`ifdef PED_LAMP_CHECK_EN
  // Sticky fault whenever the vehicle lamps are not exactly one-hot
  logic lamp_bad;
  assign lamp_bad  = ({red, yellow, green} != 3'b100) &&
                     ({red, yellow, green} != 3'b010) &&
                     ({red, yellow, green} != 3'b001);
  assign fault_nxt = lamp_fault | lamp_bad;

  always_ff @(posedge clk) begin
    if (reset) lamp_fault <= 1'b0;
    else       lamp_fault <= fault_nxt;
  end
`else
  logic unused_lamps;
  assign unused_lamps = ^{yellow, green};
  assign fault_nxt    = 1'b0;
  assign lamp_fault   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // walk_remaining doubles as the phase timer for both WALK and FLASH
  always_comb begin
    state_nxt = state;
    if (fault_nxt) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (red_edge && (req_pending || ped_btn)) state_nxt = WALK;
        WALK: begin
          if (!red)                              state_nxt = IDLE;
          else if (walk_remaining == FLASH_START) state_nxt = FLASH;
        end
        FLASH: begin
          if (!red || walk_remaining == CNT_W'(1)) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs, derived from the upcoming state
  always_comb begin
    walk_nxt      = 1'b0;
    dont_walk_nxt = 1'b1;
    rem_nxt       = '0;
    flash_cnt_nxt = '0;
    req_nxt       = req_pending;
    if (ped_btn && state != WALK) req_nxt = 1'b1;
    unique case (state_nxt)
      WALK: begin
        walk_nxt      = 1'b1;
        dont_walk_nxt = 1'b0;
        if (state == WALK) begin
          rem_nxt = walk_remaining - CNT_W'(1);
        end else begin
          rem_nxt = TOTAL;
          req_nxt = 1'b0;
        end
      end
      FLASH: begin
        rem_nxt = walk_remaining - CNT_W'(1);
        if (state == FLASH) begin
          if (flash_cnt == FH_LAST) begin
            flash_cnt_nxt = '0;
            dont_walk_nxt = ~dont_walk;
          end else begin
            flash_cnt_nxt = flash_cnt + FH_W'(1);
            dont_walk_nxt = dont_walk;
          end
        end
      end
      default: ;
    endcase
    if (fault_nxt) req_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      walk           <= 1'b0;
      dont_walk      <= 1'b1;
      req_pending    <= 1'b0;
      walk_remaining <= '0;
      flash_cnt      <= '0;
      red_d          <= 1'b1;
    end else begin
      walk           <= walk_nxt;
      dont_walk      <= dont_walk_nxt;
      req_pending    <= req_nxt;
      walk_remaining <= rem_nxt;
      flash_cnt      <= flash_cnt_nxt;
      red_d          <= red;
    end
  end

endmodule
